// File: rtl/mdu_scheduler_pkg.sv
// Shared ISA constants, FSM state encoding and MDU op codes for the MDU scheduler.
package mdu_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    function automatic logic [5:0] get_opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] get_funct(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/mdu_scheduler_if.sv
// ID-stage / MDU signal bundle for the MDU scheduler.
interface mdu_scheduler_if;
    logic [31:0] idInstruction;
    logic        idHold;
    logic        idFlush;
    logic        mduStart;
    logic [1:0]  mduOp;
    logic        mduStep;
    logic        hiLoWe;
    logic        mduBusy;
    logic        stall;

    // Pipeline side: supplies the ID instruction, consumes the MDU controls.
    modport master (
        output idInstruction, idHold, idFlush,
        input  mduStart, mduOp, mduStep, hiLoWe, mduBusy, stall
    );

    // Scheduler side.
    modport slave (
        input  idInstruction, idHold, idFlush,
        output mduStart, mduOp, mduStep, hiLoWe, mduBusy, stall
    );
endinterface

// File: rtl/mdu_scheduler_hilo_use.sv
// Combinational decoder: flags mult/div ops and any instruction touching HI/LO.
module hilo_use
    import mdu_scheduler_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic       isMd_o,
    output logic       usesHiLo_o
);

    // Only SPECIAL-opcode instructions can be mult/div or HI/LO moves.
    always_comb begin
        isMd_o     = 1'b0;
        usesHiLo_o = 1'b0;
        if (opcode_i == OPC_SPECIAL) begin
            isMd_o     = funct_i inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
            usesHiLo_o = isMd_o || (funct_i inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});
        end
    end

endmodule

// File: rtl/mdu_scheduler.sv
// Issues mult/div ops to the iterative MDU, counts its latency, strobes the
// HI/LO write and stalls HI/LO users in ID while an op is in flight.
module mdu_scheduler
    import mdu_scheduler_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic          clk,
    input  logic          resetN,
    mdu_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    mdu_op_e          op_q, op_d;
    logic             start_q, start_d;

    logic       idIsMd;
    logic       idUsesHiLo;
    logic       issue;
    logic [5:0] idFunct;

    assign idFunct = get_funct(bus.idInstruction);

    hilo_use u_hilo_use (
        .opcode_i   (get_opcode(bus.idInstruction)),
        .funct_i    (idFunct),
        .isMd_o     (idIsMd),
        .usesHiLo_o (idUsesHiLo)
    );

    assign bus.mduBusy  = (state_q != ST_IDLE);
    assign bus.stall    = bus.mduBusy & idUsesHiLo;
    assign bus.mduStart = start_q;
    assign bus.mduOp    = op_q;

    // A mult/div always counts as a HI/LO user, so issue can only fire in IDLE.
    assign issue = idIsMd & ~bus.idHold & ~bus.idFlush & ~bus.stall;

    // Next-state, counter load/decrement and per-state strobes.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        op_d        = op_q;
        start_d     = 1'b0;
        bus.mduStep = 1'b0;
        bus.hiLoWe  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                    op_d    = mdu_op_e'(idFunct[1:0]);
                    count_d = idFunct[1] ? DIV_LOAD : MUL_LOAD;
                end
            end
            ST_RUN: begin
                bus.mduStep = 1'b1;
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.hiLoWe = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any in-flight op.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            op_q    <= OP_MULT;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            start_q <= start_d;
        end
    end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed self-checking bench for mdu_scheduler (MUL_CYCLES=4, DIV_CYCLES=32).
module tb_mdu_scheduler;

    localparam logic [31:0] I_NOP   = 32'h0000_0000;
    localparam logic [31:0] I_MULT  = 32'h0085_0018;
    localparam logic [31:0] I_MULTU = 32'h0085_0019;
    localparam logic [31:0] I_DIV   = 32'h0085_001A;
    localparam logic [31:0] I_DIVU  = 32'h0085_001B;
    localparam logic [31:0] I_MFHI  = 32'h0000_1010;
    localparam logic [31:0] I_MTHI  = 32'h0080_0011;
    localparam logic [31:0] I_MFLO  = 32'h0000_1012;
    localparam logic [31:0] I_MTLO  = 32'h0080_0013;
    localparam logic [31:0] I_ADD   = 32'h0085_1020;
    localparam logic [31:0] I_LW18  = 32'h8C82_0018;
    localparam logic [31:0] I_BEQ   = 32'h1085_0003;

    logic clk = 1'b0;
    logic resetN;
    int   vecs  = 0;
    int   fails = 0;

    mdu_scheduler_if bus ();

    mdu_scheduler #(
        .MUL_CYCLES (4),
        .DIV_CYCLES (32),
        .CNT_W      (6)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check all outputs mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic st, input logic sp, input logic we,
                       input logic bsy, input logic stl, input logic [1:0] op);
        @(negedge clk);
        chk({tag, ".mduStart"}, {1'b0, bus.mduStart}, {1'b0, st});
        chk({tag, ".mduStep"},  {1'b0, bus.mduStep},  {1'b0, sp});
        chk({tag, ".hiLoWe"},   {1'b0, bus.hiLoWe},   {1'b0, we});
        chk({tag, ".mduBusy"},  {1'b0, bus.mduBusy},  {1'b0, bsy});
        chk({tag, ".stall"},    {1'b0, bus.stall},    {1'b0, stl});
        chk({tag, ".mduOp"},    bus.mduOp,            op);
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN            = 1'b0;
        bus.idInstruction = I_NOP;
        bus.idHold        = 1'b0;
        bus.idFlush       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        cyc("reset", 0, 0, 0, 0, 0, 2'd0);

        // 1: plain MULT
        bus.idInstruction = I_MULT;
        cyc("t1_issue", 0, 0, 0, 0, 0, 2'd0);
        bus.idInstruction = I_NOP;
        cyc("t1_start", 1, 1, 0, 1, 0, 2'd0);
        repeat (3) cyc("t1_step", 0, 1, 0, 1, 0, 2'd0);
        cyc("t1_done", 0, 0, 1, 1, 0, 2'd0);
        cyc("t1_idle", 0, 0, 0, 0, 0, 2'd0);

        // 2: MULT then MFLO stalls through DONE
        bus.idInstruction = I_MULT;
        cyc("t2_issue", 0, 0, 0, 0, 0, 2'd0);
        bus.idInstruction = I_MFLO;
        cyc("t2_start", 1, 1, 0, 1, 1, 2'd0);
        repeat (3) cyc("t2_step", 0, 1, 0, 1, 1, 2'd0);
        cyc("t2_done", 0, 0, 1, 1, 1, 2'd0);
        cyc("t2_release", 0, 0, 0, 0, 0, 2'd0);
        bus.idInstruction = I_NOP;

        // 3: MULT then non-HI/LO stream (incl. LW whose low bits look like MULT)
        bus.idInstruction = I_MULT;
        cyc("t3_issue", 0, 0, 0, 0, 0, 2'd0);
        bus.idInstruction = I_ADD;
        cyc("t3_start", 1, 1, 0, 1, 0, 2'd0);
        bus.idInstruction = I_LW18;
        cyc("t3_step", 0, 1, 0, 1, 0, 2'd0);
        bus.idInstruction = I_BEQ;
        cyc("t3_step", 0, 1, 0, 1, 0, 2'd0);
        bus.idInstruction = I_ADD;
        cyc("t3_step", 0, 1, 0, 1, 0, 2'd0);
        bus.idInstruction = I_BEQ;
        cyc("t3_done", 0, 0, 1, 1, 0, 2'd0);
        bus.idInstruction = I_LW18;
        repeat (2) cyc("t3_lw_noissue", 0, 0, 0, 0, 0, 2'd0);

        // 4: DIVU held two cycles; later flush/hold must not cancel it
        bus.idInstruction = I_DIVU;
        bus.idHold        = 1'b1;
        repeat (2) cyc("t4_hold", 0, 0, 0, 0, 0, 2'd0);
        bus.idHold = 1'b0;
        cyc("t4_issue", 0, 0, 0, 0, 0, 2'd0);
        bus.idInstruction = I_NOP;
        bus.idHold        = 1'b1;
        bus.idFlush       = 1'b1;
        cyc("t4_start", 1, 1, 0, 1, 0, 2'd3);
        repeat (31) cyc("t4_step", 0, 1, 0, 1, 0, 2'd3);
        cyc("t4_done", 0, 0, 1, 1, 0, 2'd3);
        bus.idHold  = 1'b0;
        bus.idFlush = 1'b0;
        cyc("t4_idle", 0, 0, 0, 0, 0, 2'd3);

        // 5: flushed DIV never issues; unflushed DIV does
        bus.idInstruction = I_DIV;
        bus.idFlush       = 1'b1;
        cyc("t5_flush", 0, 0, 0, 0, 0, 2'd3);
        bus.idFlush       = 1'b0;
        bus.idInstruction = I_NOP;
        cyc("t5_noissue", 0, 0, 0, 0, 0, 2'd3);
        bus.idInstruction = I_DIV;
        cyc("t5_issue", 0, 0, 0, 0, 0, 2'd3);
        bus.idInstruction = I_NOP;
        cyc("t5_start", 1, 1, 0, 1, 0, 2'd2);
        repeat (31) cyc("t5_step", 0, 1, 0, 1, 0, 2'd2);
        cyc("t5_done", 0, 0, 1, 1, 0, 2'd2);
        cyc("t5_idle", 0, 0, 0, 0, 0, 2'd2);

        // 6: reset on the 2nd RUN cycle abandons the op
        bus.idInstruction = I_MULTU;
        cyc("t6_issue", 0, 0, 0, 0, 0, 2'd2);
        bus.idInstruction = I_NOP;
        cyc("t6_start", 1, 1, 0, 1, 0, 2'd1);
        resetN = 1'b0;
        cyc("t6_run2", 0, 1, 0, 1, 0, 2'd1);
        resetN = 1'b1;
        cyc("t6_after_rst", 0, 0, 0, 0, 0, 2'd0);
        repeat (5) cyc("t6_no_write", 0, 0, 0, 0, 0, 2'd0);

        // 7: MULT waiting in ID during DONE of a prior MULT
        bus.idInstruction = I_MULT;
        cyc("t7_issue", 0, 0, 0, 0, 0, 2'd0);
        bus.idInstruction = I_NOP;
        cyc("t7_start", 1, 1, 0, 1, 0, 2'd0);
        repeat (3) cyc("t7_step", 0, 1, 0, 1, 0, 2'd0);
        bus.idInstruction = I_MULT;
        cyc("t7_done_stall", 0, 0, 1, 1, 1, 2'd0);
        cyc("t7_idle_issue", 0, 0, 0, 0, 0, 2'd0);
        bus.idInstruction = I_NOP;
        cyc("t7_start2", 1, 1, 0, 1, 0, 2'd0);
        repeat (3) cyc("t7_step2", 0, 1, 0, 1, 0, 2'd0);
        cyc("t7_done2", 0, 0, 1, 1, 0, 2'd0);
        cyc("t7_idle2", 0, 0, 0, 0, 0, 2'd0);

        // 8: every HI/LO user and a second mult/div stall while busy
        bus.idInstruction = I_MULTU;
        cyc("t8_issue", 0, 0, 0, 0, 0, 2'd0);
        bus.idInstruction = I_MFHI;
        cyc("t8_mfhi", 1, 1, 0, 1, 1, 2'd1);
        bus.idInstruction = I_MTHI;
        cyc("t8_mthi", 0, 1, 0, 1, 1, 2'd1);
        bus.idInstruction = I_MTLO;
        cyc("t8_mtlo", 0, 1, 0, 1, 1, 2'd1);
        bus.idInstruction = I_DIVU;
        cyc("t8_divu", 0, 1, 0, 1, 1, 2'd1);
        bus.idInstruction = I_MFLO;
        cyc("t8_done", 0, 0, 1, 1, 1, 2'd1);
        bus.idInstruction = I_NOP;
        cyc("t8_idle", 0, 0, 0, 0, 0, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
